// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, queue entry layout
// and the word-alignment helper.
package fetch_pkg;

  localparam int FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue holding {pc, instr}. A flush empties it and
// overrides any push/pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read, queue to decode, redirects
// with in-flight discard. FETCH_PERF_CNT_EN adds the perf_fetch_cnt port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  logic          mem_en_q;
  logic [CW-1:0] q_count, count_d;
  logic          q_full, q_empty;
  fetch_entry_t  q_head, push_entry;
  logic          accept, push, pop, room_next;

  assign accept     = mem_en_q && !mem_stall;
  assign if_valid   = !q_empty;
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign push       = (state_q == WAIT) && mem_done && !redirect_valid && (!q_full || pop);
  assign push_entry = '{pc: pc_q, instr: mem_data_out};

  // Occupancy after this edge decides whether the next REQ cycle may request.
  assign count_d   = redirect_valid ? '0 : (q_count + CW'(push) - CW'(pop));
  assign room_next = (count_d < CW'(QDEPTH));

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .count_o    (q_count),
    .head_o     (q_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      mem_en_q <= 1'b0;
    end else begin
      if (redirect_valid)  pc_q <= word_align(redirect_pc);
      else if (push)       pc_q <= pc_q + 32'd4;
      case (state_q)
        IDLE: begin
          state_q  <= REQ;
          mem_en_q <= room_next;
        end
        REQ: begin
          if (accept) begin
            state_q  <= redirect_valid ? DISCARD : WAIT;
            mem_en_q <= 1'b0;
          end else begin
            mem_en_q <= room_next;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state_q  <= REQ;
            mem_en_q <= room_next;
          end else if (redirect_valid) begin
            state_q  <= DISCARD;
          end
        end
        DISCARD: begin
          // The stale response retires the old request even if a new redirect
          // lands on the same cycle; waiting for another would deadlock.
          if (mem_done) begin
            state_q  <= REQ;
            mem_en_q <= room_next;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_wr      = 1'b0;
  assign mem_addr    = pc_q;
  assign mem_data_in = '0;
  assign if_instr    = q_empty ? '0 : q_head.instr;
  assign if_pc       = q_empty ? '0 : q_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       perf_q <= '0;
    else if (if_valid && if_ready && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_fetch_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic        mem_stall = 1'b0;
  logic        mem_done = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif

  int          n_pass = 0;
  int          n_total = 0;

  // responder state (owned by the responder process)
  int          acc_cnt = 0;
  bit          pend = 1'b0;
  int          cd = 0;
  logic [31:0] paddr = '0;
  // responder controls (owned by the test process)
  bit          hold = 1'b0;
  bit          inject = 1'b0;
  bit          stall_on = 1'b0;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_stall     (mem_stall),
    .mem_done      (mem_done),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return {a[15:0], 16'h0000} ^ 32'h1357_9BDF ^ a;
  endfunction

  // Memory model: drives on the falling edge; data returns one cycle after acceptance.
  always @(negedge clk) begin
    mem_done     = 1'b0;
    mem_data_out = '0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (inject) begin
        mem_done     = 1'b1;
        mem_data_out = 32'hBAD0_BAD0;
      end else if (pend && !hold) begin
        cd = cd - 1;
        if (cd <= 0) begin
          mem_done     = 1'b1;
          mem_data_out = memdata(paddr);
          pend         = 1'b0;
        end
      end
      mem_stall = stall_on;
      if (mem_en && !mem_stall) begin
        pend    = 1'b1;
        cd      = 1;
        paddr   = mem_addr;
        acc_cnt = acc_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (if_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic pop_one();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_ready = 1'b0;
    tick(); tick();
    n_total++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", mem_en); else n_pass++;
    n_total++; if (mem_addr !== 32'h2000) $display("FAIL rst_mem_addr: got %h want 00002000", mem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h want 0", if_instr); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h want 0", if_pc); else n_pass++;
    n_total++; if (mem_wr !== 1'b0 || mem_data_in !== 32'h0) $display("FAIL rst_wr_const: got %b/%h want 0/0", mem_wr, mem_data_in); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
    n_total++; if (perf_fetch_cnt !== 32'h0) $display("FAIL rst_perf: got %h want 0", perf_fetch_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_fetch();
    rst_n = 1'b1;
    tick();
    n_total++; if (mem_en !== 1'b1 || mem_addr !== 32'h2000) $display("FAIL first_req: got en=%b addr=%h want 1/00002000", mem_en, mem_addr); else n_pass++;
    tick();
    n_total++; if (mem_en !== 1'b0 || if_valid !== 1'b0) $display("FAIL wait_state: got en=%b vld=%b want 0/0", mem_en, if_valid); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", if_valid); else n_pass++;
    n_total++; if (if_pc !== 32'h2000 || if_instr !== 32'hDEAD_BEEF) $display("FAIL first_word: got %h/%h want 00002000/deadbeef", if_pc, if_instr); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    repeat (6) tick();
    n_total++; if (mem_en !== 1'b0) $display("FAIL bp_mem_en: got %b want 0", mem_en); else n_pass++;
    n_total++; if (acc_cnt !== 2) $display("FAIL bp_accepts: got %0d want 2", acc_cnt); else n_pass++;
    n_total++; if (if_pc !== 32'h2000) $display("FAIL bp_head: got %h want 00002000", if_pc); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      n_total++;
      if (!ok || if_pc !== 32'h2000 + 32'(4 * k) || if_instr !== memdata(32'h2000 + 32'(4 * k)))
        $display("FAIL bp_pop%0d: got ok=%b %h/%h want %h/%h", k, ok, if_pc, if_instr,
                 32'h2000 + 32'(4 * k), memdata(32'h2000 + 32'(4 * k)));
      else n_pass++;
      pop_one();
    end
    repeat (10) tick();
  endtask

  task automatic test_stall();
    bit ok;
    int acc0;
    acc0 = acc_cnt;
    stall_on = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        redirect_valid = 1'b0;
        n_total++; if (if_valid !== 1'b0) $display("FAIL stall_flush: got %b want 0", if_valid); else n_pass++;
      end
      n_total++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h3000 || acc_cnt !== acc0)
        $display("FAIL stall_hold%0d: got en=%b addr=%h acc=%0d want 1/00003000/%0d", i, mem_en, mem_addr, acc_cnt, acc0);
      else n_pass++;
    end
    stall_on = 1'b0;
    tick();
    n_total++; if (acc_cnt !== acc0 + 1 || mem_en !== 1'b0) $display("FAIL stall_accept: got acc=%0d en=%b want %0d/0", acc_cnt, mem_en, acc0 + 1); else n_pass++;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      n_total++;
      if (!ok || if_pc !== 32'h3000 + 32'(4 * k) || if_instr !== memdata(32'h3000 + 32'(4 * k)))
        $display("FAIL stall_order%0d: got ok=%b %h/%h want %h", k, ok, if_pc, if_instr, 32'h3000 + 32'(4 * k));
      else n_pass++;
      pop_one();
    end
    repeat (10) tick();
  endtask

  task automatic test_redirect();
    bit ok;
    int acc0;
    acc0 = acc_cnt;
    hold = 1'b1;
    pop_one();
    repeat (4) tick();
    n_total++; if (acc_cnt !== acc0 + 1 || mem_en !== 1'b0 || if_valid !== 1'b1) $display("FAIL rd_inflight: got acc=%0d en=%b vld=%b want %0d/0/1", acc_cnt, mem_en, if_valid, acc0 + 1); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h2103;
    tick();
    redirect_valid = 1'b0;
    hold = 1'b0;
    n_total++; if (if_valid !== 1'b0 || mem_en !== 1'b0) $display("FAIL rd_flush: got vld=%b en=%b want 0/0", if_valid, mem_en); else n_pass++;
    tick();
    n_total++; if (mem_en !== 1'b1 || mem_addr !== 32'h2100 || acc_cnt !== acc0 + 1) $display("FAIL rd_newreq: got en=%b addr=%h acc=%0d want 1/00002100/%0d", mem_en, mem_addr, acc_cnt, acc0 + 1); else n_pass++;
    wait_valid(ok);
    n_total++; if (!ok || if_pc !== 32'h2100 || if_instr !== memdata(32'h2100)) $display("FAIL rd_deliver: got ok=%b %h/%h want 00002100/%h", ok, if_pc, if_instr, memdata(32'h2100)); else n_pass++;
    repeat (10) tick();
  endtask

  task automatic test_wrap();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (mem_en !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got en=%b addr=%h want 1/fffffffc", mem_en, mem_addr); else n_pass++;
    repeat (8) tick();
    wait_valid(ok);
    n_total++; if (!ok || if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_first: got ok=%b %h want fffffffc", ok, if_pc); else n_pass++;
    pop_one();
    wait_valid(ok);
    n_total++; if (!ok || if_pc !== 32'h0 || if_instr !== memdata(32'h0)) $display("FAIL wrap_zero: got ok=%b %h/%h want 00000000/%h", ok, if_pc, if_instr, memdata(32'h0)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      if (if_valid === 1'b1) begin
        n_total++;
        if (if_pc !== 32'h4000 + 32'(4 * got) || if_instr !== memdata(32'h4000 + 32'(4 * got)))
          $display("FAIL b2b_%0d: got %h/%h want %h", got, if_pc, if_instr, 32'h4000 + 32'(4 * got));
        else n_pass++;
        got++;
      end
      tick();
    end
    n_total++; if (got !== 4) $display("FAIL b2b_count: got %0d want 4", got); else n_pass++;
    if_ready = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    hold = 1'b1;
    pop_one();
    repeat (3) tick();
    n_total++; if (if_valid !== 1'b1 || mem_en !== 1'b0) $display("FAIL ar_pre: got vld=%b en=%b want 1/0", if_valid, mem_en); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (mem_en !== 1'b0 || mem_addr !== 32'h2000) $display("FAIL ar_mem: got en=%b addr=%h want 0/00002000", mem_en, mem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) $display("FAIL ar_if: got %b/%h/%h want 0/0/0", if_valid, if_instr, if_pc); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
    n_total++; if (perf_fetch_cnt !== 32'h0) $display("FAIL ar_perf: got %h want 0", perf_fetch_cnt); else n_pass++;
`endif
    hold = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    n_total++; if (mem_en !== 1'b1 || mem_addr !== 32'h2000) $display("FAIL ar_restart: got en=%b addr=%h want 1/00002000", mem_en, mem_addr); else n_pass++;
    wait_valid(ok);
    n_total++; if (!ok || if_pc !== 32'h2000 || if_instr !== 32'hDEAD_BEEF) $display("FAIL ar_first: got ok=%b %h/%h want 00002000/deadbeef", ok, if_pc, if_instr); else n_pass++;
    pop_one();
    wait_valid(ok);
    n_total++; if (!ok || if_pc !== 32'h2004 || if_instr !== memdata(32'h2004)) $display("FAIL ar_second: got ok=%b %h/%h want 00002004/%h", ok, if_pc, if_instr, memdata(32'h2004)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_2000, first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, instruction queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_en  output  1  read request to memory system.
REQ-006 SHALL have port mem_wr  output  1  write strobe, constant 0.
REQ-007 SHALL have port mem_addr  output  32  word address of request, bits [1:0] = 0.
REQ-008 SHALL have port mem_data_in  output  32  write data, constant 0.
REQ-009 SHALL have port mem_data_out  input  32  read data, valid when mem_done=1.
REQ-010 SHALL have port mem_stall  input  1  memory busy; request not accepted while 1.
REQ-011 SHALL have port mem_done  input  1  one-cycle pulse, read data returned.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-013 SHALL have port redirect_pc  input  32  redirect target.
REQ-014 SHALL have port if_valid  output  1  instruction available to decode.
REQ-015 SHALL have port if_ready  input  1  decode accepts.
REQ-016 SHALL have port if_instr  output  32  instruction word.
REQ-017 SHALL have port if_pc  output  32  address of if_instr.

Function
REQ-018 SHALL run FSM states IDLE, REQ, WAIT, DISCARD; IDLE->REQ one cycle after reset release.
REQ-019 SHALL assert mem_en in REQ only when free slots (QDEPTH - occupancy) >= 1; acceptance = mem_en && !mem_stall -> WAIT.
REQ-020 SHALL hold mem_addr = pc stable while mem_en=1 and not accepted.
REQ-021 SHALL keep at most one request outstanding.
REQ-022 SHALL, in WAIT on mem_done, push {pc, mem_data_out} into queue, pc <= pc+4 (mod 2^32 wrap), return to REQ.
REQ-023 SHALL present queue head on if_valid/if_instr/if_pc; pop on if_valid && if_ready; zero extra latency (mem_done cycle N -> if_valid cycle N+1 if queue was empty).
REQ-024 SHALL allow push and pop in the same cycle; occupancy unchanged.
REQ-025 SHALL on redirect_valid: flush queue (if_valid=0 next cycle), pc <= {redirect_pc[31:2],2'b00}; simultaneous pop is discarded.
REQ-026 SHALL on redirect while WAIT (or REQ-accept same cycle) enter DISCARD, drop next mem_done data, then REQ at new pc.
REQ-027 SHALL on redirect during DISCARD update pc again and remain in DISCARD.
REQ-028 SHALL on redirect coinciding with mem_done in WAIT drop that data and go to REQ.

Reset
REQ-029 SHALL on rst_n=0 immediately: state IDLE, pc=RESET_PC, queue empty, mem_en=0, mem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
REQ-030 SHALL abandon any outstanding request on reset; a mem_done in the first cycle after release is ignored.

Configuration
REQ-031 SHALL, with FETCH_PERF_CNT_EN defined, add output perf_fetch_cnt [31:0], reset 0, +1 per if_valid&&if_ready, saturating at 32'hFFFF_FFFF.
REQ-032 SHALL, without FETCH_PERF_CNT_EN, omit the port and counter; all other behaviour identical.

Structure
REQ-033 SHALL place fetch_state_t enum, fetch_entry_t struct {pc, instr}, and FETCH_INSTR_W=32 in package fetch_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_queue (push, pop, flush, full, empty, count, head).

Verification
REQ-035 SHALL check reset fetch: release rst_n, memory returns 32'hDEAD_BEEF at 0x2000 -> mem_addr 0x2000, then if_valid with if_pc=0x2000, if_instr=32'hDEAD_BEEF.
REQ-036 SHALL check backpressure: if_ready=0 -> exactly QDEPTH words queued (0x2000, 0x2004), mem_en deasserted, no loss after if_ready=1.
REQ-037 SHALL check stall: mem_stall high 5 cycles -> mem_addr stable, single request accepted, in-order delivery.
REQ-038 SHALL check redirect mid-WAIT to 0x2103 -> in-flight data dropped, next mem_addr 0x2100, queue flushed, next if_pc 0x2100.
REQ-039 SHALL check wrap: redirect to 0xFFFF_FFFC -> following fetch address 0x0000_0000.
REQ-040 SHALL check async reset asserted mid-WAIT -> outputs at reset values same cycle, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, perf_fetch_cnt returns to 0.
